// File: rtl/game_master_fsm_multishot.sv
// Torpedo game master FSM: multi-shot rounds, key edge detect, reload on miss,
// saturating score. Moore outputs decoded from the registered state.
module game_master_fsm_multishot #(
    parameter int N_SHOTS = 3,
    parameter int SHOT_W  = 2,
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key,
    input  logic               score_clear,
    input  logic               sprite_target_within_screen,
    input  logic               sprite_torpedo_within_screen,
    input  logic               collision,
    input  logic               end_of_game_timer_running,
    output logic               sprite_target_write_xy,
    output logic               sprite_torpedo_write_xy,
    output logic               sprite_target_write_dxy,
    output logic               sprite_torpedo_write_dxy,
    output logic               sprite_target_enable_update,
    output logic               sprite_torpedo_enable_update,
    output logic               end_of_game_timer_start,
    output logic               game_won,
    output logic [SHOT_W-1:0]  shots_left,
    output logic [SCORE_W-1:0] score
);

    typedef enum logic [3:0] {
        S_IDLE, S_START_TGT, S_WAIT_KEY, S_LAUNCH, S_FLIGHT,
        S_RELOAD, S_END_START, S_WON, S_LOST
    } state_t;

    state_t             state_q, state_d;
    logic [SHOT_W-1:0]  shots_left_q, shots_left_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               won_flag_q, won_flag_d;
    logic               key_prev_q, key_prev_d;
    logic               key_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shots_left_q <= '0;
            score_q      <= '0;
            won_flag_q   <= 1'b0;
            key_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shots_left_q <= shots_left_d;
            score_q      <= score_d;
            won_flag_q   <= won_flag_d;
            key_prev_q   <= key_prev_d;
        end
    end

    assign key_rise = key & ~key_prev_q;

    always_comb begin
        state_d      = state_q;
        shots_left_d = shots_left_q;
        score_d      = score_q;
        won_flag_d   = won_flag_q;
        key_prev_d   = key;

        sprite_target_write_xy       = 1'b0;
        sprite_torpedo_write_xy      = 1'b0;
        sprite_target_write_dxy      = 1'b0;
        sprite_torpedo_write_dxy     = 1'b0;
        sprite_target_enable_update  = 1'b0;
        sprite_torpedo_enable_update = 1'b0;
        end_of_game_timer_start      = 1'b0;
        game_won                     = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_START_TGT;
            S_START_TGT: begin
                sprite_target_write_xy  = 1'b1;
                sprite_torpedo_write_xy = 1'b1;
                sprite_target_write_dxy = 1'b1;
                shots_left_d            = SHOT_W'(N_SHOTS);
                won_flag_d              = 1'b0;
                state_d                 = S_WAIT_KEY;
            end
            S_WAIT_KEY: begin
                sprite_target_enable_update = 1'b1;
                sprite_torpedo_write_dxy    = 1'b1;
                if (key_rise && shots_left_q != '0)    state_d = S_LAUNCH;
                else if (!sprite_target_within_screen) state_d = S_END_START;
            end
            S_LAUNCH: begin
                shots_left_d = shots_left_q - 1'b1;
                state_d      = S_FLIGHT;
            end
            S_FLIGHT: begin
                sprite_target_enable_update  = 1'b1;
                sprite_torpedo_enable_update = 1'b1;
                sprite_torpedo_write_dxy     = 1'b1;
                // A hit beats the target leaving screen in the same cycle.
                if (collision) begin
                    won_flag_d = 1'b1;
                    state_d    = S_END_START;
                end else if (!sprite_target_within_screen) begin
                    state_d = S_END_START;
                end else if (!sprite_torpedo_within_screen) begin
                    state_d = (shots_left_q == '0) ? S_END_START : S_RELOAD;
                end
            end
            S_RELOAD: begin
                sprite_torpedo_write_xy = 1'b1;
                state_d                 = S_WAIT_KEY;
            end
            S_END_START: begin
                end_of_game_timer_start = 1'b1;
                if (won_flag_q && score_q != '1) score_d = score_q + 1'b1;
                state_d = won_flag_q ? S_WON : S_LOST;
            end
            S_WON: begin
                game_won = 1'b1;
                if (!end_of_game_timer_running) state_d = S_START_TGT;
            end
            S_LOST: begin
                if (!end_of_game_timer_running) state_d = S_START_TGT;
            end
            default: state_d = S_IDLE;
        endcase

        if (score_clear) score_d = '0;
    end

    assign shots_left = shots_left_q;
    assign score      = score_q;

endmodule
